spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI Mode 0 (CPOL=0, CPHA=0) slave with a parameterised word length, MSB first.
- Clocked solely by the SPI serial clock `sclk`.
- Receives MOSI into a receive shift register and presents each completed word on `outData`.
- Transmits a word preloaded from `inData` via `latch` on MISO, with an output-enable for a shared/tri-stated MISO line.

Parameters:
BITS, 8, word length in bits (>= 2); width of inData/outData and both shift registers.

Ports:
sclk  input  1  SPI serial clock; the only clock. Rising edge samples, falling edge shifts.
rst  input  1  reset, asynchronous, active-low (0 = reset).
ss_n  input  1  slave select, active-low.
mosi  input  1  master-out serial data, sampled on sclk rising edge.
miso  output  1  slave-out serial data; MSB of transmit register.
miso_oe  output  1  MISO output enable, = ~ss_n.
latch  input  1  load request: copies inData into the transmit register.
inData  input  BITS  word to transmit.
outData  output  BITS  last fully received word.

Behaviour:
- One clock; reset is asynchronous and active-low. While rst=0:
  - tx_sr, rx_sr, outData = 0.
  - Bit counter = 0, shift-enable flag = 0.
- ss_n=1 asynchronously clears the bit counter and the shift-enable flag (framing). Data registers are kept.
- Load:
  - On sclk rising edge with ss_n=1 and latch=1: tx_sr <= inData.
  - latch is ignored while ss_n=0.
  - latch must be held high across at least one sclk rising edge.
- miso = tx_sr[BITS-1] at all times (combinational from register). miso_oe = ~ss_n.
  - Because of this, the first bit is valid as soon as ss_n falls, before the first rising edge.
- Rising edge, ss_n=0:
  - rx_sr <= {rx_sr[BITS-2:0], mosi}.
  - Bit counter increments.
  - Shift-enable flag <= 1.
  - When the counter reaches BITS-1 → 0 wrap (i.e. the BITS-th sampled bit): outData <= {rx_sr[BITS-2:0], mosi} in the same edge.
- Falling edge, ss_n=0, shift-enable flag=1: tx_sr <= {tx_sr[BITS-2:0], 1'b0}.
  - A falling edge before the first rising edge of a frame does not shift, so the MSB is never lost.
- Continuous transfer (ss_n held low past BITS bits):
  - Counter wraps modulo BITS.
  - Each further BITS bits updates outData.
  - MISO outputs 0s once the loaded word is exhausted; no automatic reload.
- ss_n raised mid-word:
  - Partial rx bits are discarded; outData is unchanged.
  - Counter restarts at 0 on the next frame.
  - tx_sr keeps its partially shifted value until the next latch.
- Reset mid-transfer: all state cleared immediately; miso=0.
- Bit counter width: clog2(BITS).

Decomposition:
- No shared package needed; only local constant CNT_W = clog2(BITS).
- Single module. Optional sub-module spi_shift_reg (parameterised shift register with parallel load) instantiated for tx and rx.

Test Plan:
- Reset: rst=0 with sclk running → outData=0x00, miso=0, miso_oe=0. After release with ss_n=1, miso_oe=0.
- Basic exchange (BITS=8):
  - Stimulus: latch inData=0x65 with ss_n=1, then ss_n=0; master drives 0xC5 MSB-first (changes on falling, samples on rising) for 8 clocks.
  - Required: master reads 0x65; outData=0xC5 at the 8th rising edge; miso_oe=1 throughout.
- First-bit timing: after latching 0x80, lower ss_n with sclk low → miso=1 before the first rising edge. miso=0 after the first falling edge that follows a rising edge.
- Continuous 16-bit frame:
  - Stimulus: latch 0xA5, master sends 0x3C then 0xFF.
  - Required: master reads 0xA5 then 0x00; outData=0x3C after edge 8 and 0xFF after edge 16.
- Aborted frame:
  - Stimulus: outData already 0x3C; raise ss_n after 3 bits of 0xF0; then start a new full frame sending 0x5A.
  - Required: outData stays 0x3C across the abort and becomes 0x5A after the new frame (counter restarted).
- latch during ss_n=0 with inData=0xFF mid-frame → ignored; MISO continues the previously latched word.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared constants and helpers for the SPI Mode 0 slave.
package spi_slave_pkg;

    localparam int DEFAULT_BITS = 8;

    // Bit counter width; a 2-bit word still needs one counter bit.
    function automatic int cntWidth(input int bits);
        return (bits > 2) ? $clog2(bits) : 1;
    endfunction

endpackage

// File: rtl/spi_slave_shift_reg.sv
// MSB-first shift register with parallel load; a load and a shift may happen on the same edge.
module spi_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_loadData,
    input  logic         i_shift,
    input  logic         i_serIn,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;
    logic [W-1:0] w_base;

    always_comb begin
        w_base = r_q;
        if (i_load) begin
            w_base = i_loadData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_shift) begin
            r_q <= {w_base[W-2:0], i_serIn};
        end else begin
            r_q <= w_base;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/spi_slave.sv
// SPI Mode 0 slave clocked only by sclk: samples MOSI on rising edges, shifts MISO on falling edges.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            sclk,
    input  logic            rst,
    input  logic            ss_n,
    input  logic            mosi,
    output logic            miso,
    output logic            miso_oe,
    input  logic            latch,
    input  logic [BITS-1:0] inData,
    output logic [BITS-1:0] outData
);

    localparam int CNT_W = cntWidth(BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS - 1);

    logic             w_frameClr;
    logic             w_sclkN;
    logic [CNT_W-1:0] r_bitCnt;
    logic             r_shiftEn;
    logic [BITS-1:0]  r_outData;
    logic [BITS-1:0]  r_txWord;
    logic             r_txGen;
    logic             r_txGenSeen;
    logic             w_txLoad;
    logic             w_txShift;
    logic [BITS-1:0]  w_txSr;
    logic [BITS-1:0]  w_rxSr;

    assign w_frameClr = ~rst | ss_n;
    assign w_sclkN    = ~sclk;

    // Framing state is cleared the moment the slave is deselected.
    always_ff @(posedge sclk or posedge w_frameClr) begin
        if (w_frameClr) begin
            r_bitCnt  <= '0;
            r_shiftEn <= 1'b0;
        end else begin
            r_shiftEn <= 1'b1;
            if (r_bitCnt == LAST_BIT) begin
                r_bitCnt <= '0;
            end else begin
                r_bitCnt <= r_bitCnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_outData <= '0;
        end else if (!ss_n && (r_bitCnt == LAST_BIT)) begin
            r_outData <= {w_rxSr[BITS-2:0], mosi};
        end
    end

    // A rising-edge load is handed to the falling-edge tx register by toggling a generation bit.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_txWord <= '0;
            r_txGen  <= 1'b0;
        end else if (ss_n && latch) begin
            r_txWord <= inData;
            r_txGen  <= ~r_txGen;
        end
    end

    always_ff @(negedge sclk or negedge rst) begin
        if (!rst) begin
            r_txGenSeen <= 1'b0;
        end else begin
            r_txGenSeen <= r_txGen;
        end
    end

    assign w_txLoad  = r_txGen != r_txGenSeen;
    assign w_txShift = ~ss_n & r_shiftEn;

    spi_shift_reg #(.W(BITS)) u_txShift (
        .clk        (w_sclkN),
        .rst_n      (rst),
        .i_load     (w_txLoad),
        .i_loadData (r_txWord),
        .i_shift    (w_txShift),
        .i_serIn    (1'b0),
        .o_q        (w_txSr)
    );

    spi_shift_reg #(.W(BITS)) u_rxShift (
        .clk        (sclk),
        .rst_n      (rst),
        .i_load     (1'b0),
        .i_loadData ('0),
        .i_shift    (~ss_n),
        .i_serIn    (mosi),
        .o_q        (w_rxSr)
    );

    // A pending load is not yet in the tx register, so MISO shows the new word directly.
    assign miso    = w_txLoad ? r_txWord[BITS-1] : w_txSr[BITS-1];
    assign miso_oe = ~ss_n;
    assign outData = r_outData;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed scenarios plus random frames against a word-level model.
module tb_spi_slave;

    localparam int BITS = 8;

    logic            sclk = 1'b0;
    logic            rst = 1'b0;
    logic            ss_n = 1'b1;
    logic            mosi = 1'b0;
    logic            latch = 1'b0;
    logic [BITS-1:0] inData = '0;
    logic            miso;
    logic            miso_oe;
    logic [BITS-1:0] outData;

    int errors = 0;
    int checks = 0;

    // Reference model: loaded word, how many bits of it have left, partial rx frame, last full word.
    logic [BITS-1:0] mWord;
    int              mShift;
    bit              mEn;
    int              mCnt;
    logic [BITS-1:0] mRx;
    logic [BITS-1:0] mOut;

    spi_slave #(.BITS(BITS)) dut (
        .sclk    (sclk),
        .rst     (rst),
        .ss_n    (ss_n),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .latch   (latch),
        .inData  (inData),
        .outData (outData)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic expMiso();
        return (mShift < BITS) ? mWord[BITS-1-mShift] : 1'b0;
    endfunction

    task automatic modelReset();
        mWord  = '0;
        mShift = 0;
        mEn    = 1'b0;
        mCnt   = 0;
        mRx    = '0;
        mOut   = '0;
    endtask

    task automatic doLoad(input logic [BITS-1:0] w);
        ss_n   = 1'b1;
        inData = w;
        latch  = 1'b1;
        #5 sclk = 1'b1;
        mWord  = w;
        mShift = 0;
        #5 sclk = 1'b0;
        #1 latch = 1'b0;
        inData = BITS'($urandom);
        #4;
    endtask

    task automatic selectSlave();
        ss_n = 1'b0;
        #5;
        checkOutput("miso_oe_selected", {31'd0, miso_oe}, 32'd1);
        checkOutput("miso_first_bit", {31'd0, miso}, {31'd0, expMiso()});
    endtask

    task automatic deselect();
        ss_n = 1'b1;
        mCnt = 0;
        mEn  = 1'b0;
        #5;
        checkOutput("miso_oe_deselected", {31'd0, miso_oe}, 32'd0);
        checkOutput("outData_after_frame", {24'd0, outData}, {24'd0, mOut});
    endtask

    // One full sclk period: master drives MOSI while sclk is low, samples MISO just before the rise.
    task automatic applyStimulus(input logic m, input logic tryLatch, output logic readBit);
        mosi  = m;
        latch = tryLatch;
        if (tryLatch) begin
            inData = '1;
        end
        #4;
        readBit = miso;
        checkOutput("miso", {31'd0, miso}, {31'd0, expMiso()});
        checkOutput("miso_oe", {31'd0, miso_oe}, 32'd1);
        sclk = 1'b1;
        mRx  = {mRx[BITS-2:0], m};
        mCnt++;
        mEn  = 1'b1;
        if (mCnt == BITS) begin
            mOut = mRx;
            mCnt = 0;
        end
        #3;
        checkOutput("outData", {24'd0, outData}, {24'd0, mOut});
        #2 sclk = 1'b0;
        if (mEn && mShift < BITS) begin
            mShift++;
        end
        #1 latch = 1'b0;
        #4;
    endtask

    task automatic sendWord(input logic [BITS-1:0] w, input int nbits, input bit tryLatch,
                            output logic [BITS-1:0] got);
        logic b;
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            applyStimulus(w[BITS-1-i], tryLatch, b);
            got = {got[BITS-2:0], b};
        end
    endtask

    initial begin
        logic [BITS-1:0] got;
        logic [BITS-1:0] got2;
        logic            b;
        int              nbits;

        modelReset();

        // Reset held with sclk toggling and a load request that must not take effect.
        rst    = 1'b0;
        latch  = 1'b1;
        inData = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            #5 sclk = 1'b1;
            #5 sclk = 1'b0;
        end
        latch = 1'b0;
        checkOutput("reset_outData", {24'd0, outData}, 32'h00);
        checkOutput("reset_miso", {31'd0, miso}, 32'd0);
        checkOutput("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
        rst = 1'b1;
        #5;
        checkOutput("release_miso_oe", {31'd0, miso_oe}, 32'd0);
        checkOutput("release_miso", {31'd0, miso}, 32'd0);

        $display("[TB] basic exchange");
        doLoad(8'h65);
        selectSlave();
        sendWord(8'hC5, 8, 1'b0, got);
        checkOutput("basic_read", {24'd0, got}, 32'h65);
        checkOutput("basic_outData", {24'd0, outData}, 32'hC5);
        deselect();

        $display("[TB] first-bit timing");
        doLoad(8'h80);
        #5 sclk = 1'b1;
        #5 ss_n = 1'b0;
        #2;
        checkOutput("first_bit_before_rise", {31'd0, miso}, 32'd1);
        sclk = 1'b0;
        #5;
        checkOutput("fall_before_rise_no_shift", {31'd0, miso}, 32'd1);
        applyStimulus(1'b0, 1'b0, b);
        checkOutput("first_bit_read", {31'd0, b}, 32'd1);
        checkOutput("second_bit_after_fall", {31'd0, miso}, 32'd0);
        deselect();

        $display("[TB] continuous 16-bit frame");
        doLoad(8'hA5);
        selectSlave();
        sendWord(8'h3C, 8, 1'b0, got);
        checkOutput("cont_read_first", {24'd0, got}, 32'hA5);
        checkOutput("cont_outData_first", {24'd0, outData}, 32'h3C);
        sendWord(8'hFF, 8, 1'b0, got2);
        checkOutput("cont_read_second", {24'd0, got2}, 32'h00);
        checkOutput("cont_outData_second", {24'd0, outData}, 32'hFF);
        deselect();

        $display("[TB] aborted frame");
        doLoad(8'h11);
        selectSlave();
        sendWord(8'h3C, 8, 1'b0, got);
        deselect();
        selectSlave();
        sendWord(8'hF0, 3, 1'b0, got);
        deselect();
        checkOutput("abort_outData_kept", {24'd0, outData}, 32'h3C);
        selectSlave();
        sendWord(8'h5A, 8, 1'b0, got);
        checkOutput("abort_new_frame", {24'd0, outData}, 32'h5A);
        deselect();

        $display("[TB] latch ignored while selected");
        doLoad(8'h81);
        selectSlave();
        sendWord(8'h00, 3, 1'b0, got);
        sendWord(8'h00, 5, 1'b1, got2);
        checkOutput("latch_ignored_read", {24'd0, got[2:0], got2[4:0]}, 32'h81);
        deselect();

        $display("[TB] reset mid-transfer");
        doLoad(8'hC3);
        selectSlave();
        sendWord(8'hAB, 4, 1'b0, got);
        rst = 1'b0;
        #2;
        checkOutput("midreset_miso", {31'd0, miso}, 32'd0);
        checkOutput("midreset_outData", {24'd0, outData}, 32'h00);
        modelReset();
        #3 rst = 1'b1;
        deselect();

        $display("[TB] random frames");
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                doLoad(BITS'($urandom));
            end
            selectSlave();
            nbits = $urandom_range(1, 20);
            for (int i = 0; i < nbits; i++) begin
                applyStimulus(1'($urandom), ($urandom_range(0, 4) == 0), b);
            end
            deselect();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
